// File: rtl/opb_register_bank_if.sv
// OPB slave-side bus bundle for opb_register_bank; bit 0 of every vector is the MSB.
interface opb_register_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS byte-writable 32-bit user registers.
// Define OPB_REGBANK_SHADOW_EN to stage writes in shadows, published by a write to word C_NUM_REGS.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR = 32'h01100600,
  parameter logic [31:0] C_HIGHADDR = 32'h011006FF,
  parameter int unsigned C_NUM_REGS = 4
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst_n,
  opb_register_bank_if.slave           bus,
  output logic [32*C_NUM_REGS-1:0]     user_data_out,
  output logic [C_NUM_REGS-1:0]        user_data_valid
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_ACK  = 2'd1;
  localparam logic [1:0]  S_WAIT = 2'd2;
  localparam logic [29:0] NUM_W  = 30'(C_NUM_REGS);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr, offset, rd_mux;
  logic [29:0] word;
  logic        in_range, claim, hit, cmt;
  logic [31:0] vis    [C_NUM_REGS];
  logic [31:0] user_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] valid_q;
  logic [3:0]  idx_q, be_q;
  logic [31:0] wdata_q, rdata_q;
  logic        wr_q, hit_q, cmt_q, ack_q, err_q;
  logic        unused_ok;

  assign addr     = bus.OPB_ABus;
  assign offset   = addr - C_BASEADDR;
  assign word     = offset[31:2];
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign claim    = bus.OPB_select && in_range;
  assign hit      = word < NUM_W;

`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0] shadow_q [C_NUM_REGS];
  assign cmt = (word == NUM_W);
  always_comb begin
    for (int unsigned k = 0; k < C_NUM_REGS; k++) vis[k] = shadow_q[k];
  end
`else
  assign cmt = 1'b0;
  always_comb begin
    for (int unsigned k = 0; k < C_NUM_REGS; k++) vis[k] = user_q[k];
  end
`endif

  // Commit word (shadow build) falls through the mux and reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < C_NUM_REGS; k++)
      if (word == 30'(k)) rd_mux = vis[k];
  end

  // be[3] is the bus BE[0] lane, i.e. register bits [31:24].
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (claim) state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!bus.OPB_select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      cmt_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= '0;
      for (int unsigned k = 0; k < C_NUM_REGS; k++) user_q[k] <= '0;
`ifdef OPB_REGBANK_SHADOW_EN
      for (int unsigned k = 0; k < C_NUM_REGS; k++) shadow_q[k] <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= '0;
      case (state_q)
        S_IDLE: if (claim) begin
          idx_q   <= word[3:0];
          hit_q   <= hit;
          cmt_q   <= cmt;
          wr_q    <= !bus.OPB_RNW;
          be_q    <= bus.OPB_BE;
          wdata_q <= bus.OPB_DBus;
          ack_q   <= hit || cmt;
          err_q   <= !(hit || cmt);
          if (bus.OPB_RNW && hit) rdata_q <= rd_mux;
        end
        // Write data lands on the edge closing the ACK cycle, so a reset during ACK drops it.
        S_ACK: if (wr_q) begin
`ifdef OPB_REGBANK_SHADOW_EN
          for (int unsigned k = 0; k < C_NUM_REGS; k++)
            if (hit_q && idx_q == 4'(k)) shadow_q[k] <= merge(shadow_q[k], wdata_q, be_q);
          if (cmt_q) begin
            for (int unsigned k = 0; k < C_NUM_REGS; k++) user_q[k] <= shadow_q[k];
            valid_q <= '1;
          end
`else
          for (int unsigned k = 0; k < C_NUM_REGS; k++)
            if (hit_q && idx_q == 4'(k)) begin
              user_q[k]  <= merge(user_q[k], wdata_q, be_q);
              valid_q[k] <= 1'b1;
            end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int unsigned k = 0; k < C_NUM_REGS; k++) user_data_out[32*k +: 32] = user_q[k];
  end

  assign user_data_valid = valid_q;
  assign bus.Sl_DBus     = rdata_q;
  assign bus.Sl_xferAck  = ack_q;
  assign bus.Sl_errAck   = err_q;
  assign bus.Sl_retry    = 1'b0;
  assign bus.Sl_toutSup  = 1'b0;
  assign unused_ok       = ^{offset[1:0], bus.OPB_seqAddr, cmt_q};

endmodule

// File: tb/tb_opb_register_bank.sv
// Scoreboard bench for opb_register_bank: a byte-lane reference model predicts acks, read data and update strobes.
module tb_opb_register_bank;
  localparam logic [31:0] BASE = 32'h01100600;
  localparam logic [31:0] HIGH = 32'h011006FF;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  opb_register_bank_if bus_if ();
  logic [32*NR-1:0] udo;
  logic [NR-1:0]    udv;

  opb_register_bank #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NR)) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .bus(bus_if),
    .user_data_out(udo), .user_data_valid(udv)
  );

  typedef struct { logic xack; logic [31:0] data; } resp_t;
  typedef struct { logic [NR-1:0] mask; logic [32*NR-1:0] out; } upd_t;
  resp_t rq[$];
  upd_t  vq[$];

  logic [31:0] user_m   [NR];
  logic [31:0] shadow_m [NR];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] nw, input logic [0:3] be);
    logic [31:0] r;
    r = old;
    for (int lane = 0; lane < 4; lane++)
      if (be[lane]) r[31-8*lane -: 8] = nw[31-8*lane -: 8];
    return r;
  endfunction

  function automatic logic [32*NR-1:0] flat();
    logic [32*NR-1:0] o;
    for (int k = 0; k < NR; k++) o[32*k +: 32] = user_m[k];
    return o;
  endfunction

  task automatic predict(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                         input logic [31:0] data, output bit resp);
    int w;
    resp = 0;
    if (addr < BASE || addr > HIGH) return;
    resp = 1;
    w = int'((addr - BASE) / 4);
    if (w < NR) begin
`ifdef OPB_REGBANK_SHADOW_EN
      rq.push_back('{1'b1, rnw ? shadow_m[w] : 32'h0});
      if (!rnw) shadow_m[w] = apply_be(shadow_m[w], data, be);
`else
      rq.push_back('{1'b1, rnw ? user_m[w] : 32'h0});
      if (!rnw) begin
        user_m[w] = apply_be(user_m[w], data, be);
        vq.push_back('{NR'(1) << w, flat()});
      end
`endif
    end
`ifdef OPB_REGBANK_SHADOW_EN
    else if (w == NR) begin
      rq.push_back('{1'b1, 32'h0});
      if (!rnw) begin
        for (int k = 0; k < NR; k++) user_m[k] = shadow_m[k];
        vq.push_back('{{NR{1'b1}}, flat()});
      end
    end
`endif
    else rq.push_back('{1'b0, 32'h0});
  endtask

  task automatic bus_idle();
    bus_if.OPB_select  = 1'b0;
    bus_if.OPB_RNW     = 1'b1;
    bus_if.OPB_ABus    = '0;
    bus_if.OPB_BE      = '0;
    bus_if.OPB_DBus    = '0;
    bus_if.OPB_seqAddr = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                      input logic [31:0] data, input int hold);
    bit resp;
    int n;
    predict(addr, rnw, be, data, resp);
    @(negedge clk);
    bus_if.OPB_ABus    = addr;
    bus_if.OPB_RNW     = rnw;
    bus_if.OPB_BE      = be;
    bus_if.OPB_DBus    = data;
    bus_if.OPB_seqAddr = 1'($urandom_range(0, 1));
    bus_if.OPB_select  = 1'b1;
    if (resp) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus_if.Sl_xferAck || bus_if.Sl_errAck) && n < 8);
      chk("ack_latency", n == 1, 128'(n), 128'(1));
    end else begin
      repeat (4) @(negedge clk);
    end
    repeat (hold) @(negedge clk);
    bus_idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_out(input string name);
    chk(name, udo == flat(), 128'(udo), 128'(flat()));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.Sl_xferAck || bus_if.Sl_errAck) begin
        if (rq.size() == 0) begin
          chk("unexpected_ack", 1'b0, 128'({bus_if.Sl_xferAck, bus_if.Sl_errAck}), 128'(0));
        end else begin
          resp_t e;
          e = rq.pop_front();
          chk("ack_kind", bus_if.Sl_xferAck == e.xack && bus_if.Sl_errAck == !e.xack,
              128'({bus_if.Sl_xferAck, bus_if.Sl_errAck}), 128'({e.xack, !e.xack}));
          chk("read_data", bus_if.Sl_DBus == e.data, 128'(bus_if.Sl_DBus), 128'(e.data));
        end
      end else begin
        chk("dbus_idle_zero", bus_if.Sl_DBus == 32'h0, 128'(bus_if.Sl_DBus), 128'(0));
      end
      if (udv != '0) begin
        if (vq.size() == 0) begin
          chk("unexpected_valid", 1'b0, 128'(udv), 128'(0));
        end else begin
          upd_t u;
          u = vq.pop_front();
          chk("valid_mask", udv == u.mask, 128'(udv), 128'(u.mask));
          chk("update_data", udo == u.out, 128'(udo), 128'(u.out));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    for (int k = 0; k < NR; k++) begin
      user_m[k]   = '0;
      shadow_m[k] = '0;
    end
    bus_idle();
    repeat (3) @(negedge clk);
    chk("reset_acks", {bus_if.Sl_xferAck, bus_if.Sl_errAck} == 2'b00,
        128'({bus_if.Sl_xferAck, bus_if.Sl_errAck}), 128'(0));
    chk("reset_dbus", bus_if.Sl_DBus == 32'h0, 128'(bus_if.Sl_DBus), 128'(0));
    chk("reset_udo", udo == '0, 128'(udo), 128'(0));
    chk("reset_udv", udv == '0, 128'(udv), 128'(0));
    chk("tied_low", {bus_if.Sl_retry, bus_if.Sl_toutSup} == 2'b00,
        128'({bus_if.Sl_retry, bus_if.Sl_toutSup}), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset lands in the ACK cycle of a write: nothing is acked or committed
    bus_if.OPB_ABus   = BASE;
    bus_if.OPB_RNW    = 1'b0;
    bus_if.OPB_BE     = 4'b1111;
    bus_if.OPB_DBus   = 32'hFFFFFFFF;
    bus_if.OPB_select = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_ack", {bus_if.Sl_xferAck, bus_if.Sl_errAck} == 2'b00,
           128'({bus_if.Sl_xferAck, bus_if.Sl_errAck}), 128'(0));
    @(negedge clk);
    chk("abort_udo", udo == '0, 128'(udo), 128'(0));
    chk("abort_udv", udv == '0, 128'(udv), 128'(0));
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'hDEADBEEF, 0);
    check_out("out_after_deadbeef");
    xfer(BASE, 1'b0, 4'b1111, 32'h11223344, 0);
    xfer(BASE, 1'b0, 4'b0101, 32'hAABBCCDD, 0);
    xfer(BASE, 1'b1, 4'b1111, 32'h0, 0);
    check_out("out_after_partial");
    xfer(BASE + 32'h8, 1'b0, 4'b0000, 32'hFFFFFFFF, 0);
    xfer(BASE + 32'h40, 1'b1, 4'b1111, 32'h0, 0);
    xfer(HIGH + 32'h4, 1'b0, 4'b1111, 32'h12345678, 0);
    check_out("out_after_bad_addr");
    xfer(BASE, 1'b1, 4'b1111, 32'h0, 4);
    xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h0, 0);
`ifdef OPB_REGBANK_SHADOW_EN
    xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h5, 0);
    check_out("shadow_no_publish");
    xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, 0);
    xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'hCAFE0000, 0);
    check_out("out_after_commit");
    xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        6:       a = BASE + 32'h40;
        7:       a = BASE - 32'($urandom_range(1, 8));
        8:       a = HIGH + 32'($urandom_range(1, 16));
        9:       a = HIGH - 32'h3;
        default: a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
      endcase
      xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    check_out("out_final");
    chk("resp_queue_drained", rq.size() == 0, 128'(rq.size()), 128'(0));
    chk("valid_queue_drained", vq.size() == 0, 128'(vq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
